pc_ras: RTL and testbench
=========================

# pc_ras

Parametrised program-counter unit with stall, absolute and PC-relative branching, and a hardware return-address stack (RAS) for call/return. It replaces the fixed-width counter at the front of the fetch stage and drives the instruction-memory address each cycle. It also gives the decode/control logic stack-status and redirect indications.

## Interface

- D, 8, PC / address width in bits
- OFS_W, 8, width of signed relative offset (OFS_W <= D)
- RAS_DEPTH, 4, return-address stack entries (>= 2)
- RESET_VEC, 0, value loaded into prog_ctr on reset
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- stall  input  1  hold all state this cycle
- branch  input  1  absolute jump to target
- rel_branch  input  1  relative jump by offset
- call  input  1  push return address, jump to target
- ret  input  1  pop return address, jump to it
- target  input  D  absolute destination for branch/call
- offset  input  OFS_W  two's-complement relative displacement
- prog_ctr  output  D  current PC (registered)
- redirect  output  1  registered; 1 for the cycle after a non-sequential PC update
- ras_empty  output  1  stack holds 0 entries
- ras_full  output  1  stack holds RAS_DEPTH entries
- ras_ovf  output  1  sticky: call attempted while full
- ras_unf  output  1  sticky: ret attempted while empty

## Operation

- Control inputs are evaluated with fixed priority: stall > ret > call > branch > rel_branch > sequential.
- stall: prog_ctr, stack, count, and sticky flags are held. redirect <= 0.
- ret, stack not empty: prog_ctr <= top entry; count decrements; redirect <= 1.
- ret, stack empty: prog_ctr <= prog_ctr + 1; ras_unf <= 1; redirect <= 0.
- call, stack not full: push prog_ctr + 1 (mod 2^D); prog_ctr <= target; count increments; redirect <= 1.
- call, stack full: the jump to target still occurs, the push is discarded, stack contents and count are unchanged, ras_ovf <= 1, redirect <= 1.
- branch: prog_ctr <= target; redirect <= 1.
- rel_branch: prog_ctr <= prog_ctr + sign_extend(offset) truncated to D bits; redirect <= 1.
  - offset 0 is legal and gives a self-loop; redirect is still 1.
- Sequential: prog_ctr <= prog_ctr + 1; redirect <= 0.
- All PC arithmetic is modulo 2^D: 2^D-1 + 1 wraps to 0, and a negative offset below 0 wraps to the top of the range.
- Stack is LIFO, implemented as a register array plus a count of width clog2(RAS_DEPTH+1). Only the top entry is readable.
- ras_empty = (count == 0) and ras_full = (count == RAS_DEPTH), both decoded combinationally from the registered count.
- ras_ovf and ras_unf stay set until reset. No other input clears them.

## Timing

- Reset (reset = 0) is asynchronous and takes effect immediately, independent of clk:
  - prog_ctr = RESET_VEC, count = 0, redirect = 0, ras_ovf = 0, ras_unf = 0.
  - Therefore ras_empty = 1 and ras_full = 0.
  - Stack entry contents are don't-care.
- A reset asserted mid-call or mid-stall discards all stack state.
- Deassertion of reset is synchronised externally. The first update happens on the first rising edge with reset = 1.
- Latency: an input sampled at edge N is visible on prog_ctr and the flags after edge N. No combinational path exists from any input to any output.
- Simultaneous ret and call: ret wins, call is ignored entirely (no push, no ovf).
- Simultaneous call/branch/rel_branch: the higher priority wins. The others are ignored.
- Back-to-back call then ret on consecutive cycles returns to call-site + 1.
- With RAS_DEPTH = 4, exactly 4 nested calls fill the stack. The 5th call sets ras_ovf.

## Test plan

- Reset and sequence (D=8, RESET_VEC=0): hold reset=0, then release and run 3 idle cycles -> prog_ctr 0,1,2,3; redirect 0; ras_empty 1. Assert reset asynchronously between edges -> prog_ctr 0 immediately.
- Wrap and relative:
  - branch target=0xFE, then idle -> 0xFE, 0xFF, 0x00.
  - At 0x05, rel_branch offset=0xFB (-5) -> 0x00 with redirect=1.
  - At 0xFE, rel_branch offset=0x04 -> 0x02.
- Call/return nesting:
  - call target=0x40 at pc 0x10, then call target=0x80 at 0x41 -> count 2.
  - ret -> 0x42; ret -> 0x11; ras_empty 1.
- Overflow/underflow:
  - 5 calls with DEPTH=4 -> 5th jumps to target, ras_full 1, ras_ovf 1.
  - 4 rets return in LIFO order; a 5th ret -> pc+1, ras_unf 1.
  - Both flags stay 1 until reset.
- Priority and stall:
  - stall=1 with call=1 -> pc and count unchanged, redirect 0.
  - ret=1 and call=1 with 1 entry -> pops, no push.
  - branch=1 and rel_branch=1 -> pc = target.

Source files
------------

// File: rtl/pc_ras.sv
// Program counter with stall, absolute/relative branching and a return-address
// stack for call/return; drives the instruction-memory address every cycle.
module pc_ras #(
    parameter int             D         = 8,
    parameter int             OFS_W     = 8,
    parameter int             RAS_DEPTH = 4,
    parameter logic [D-1:0]   RESET_VEC = {D{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic             rel_branch,
    input  logic             call,
    input  logic             ret,
    input  logic [D-1:0]     target,
    input  logic [OFS_W-1:0] offset,
    output logic [D-1:0]     prog_ctr,
    output logic             redirect,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);

    localparam int            CW      = $clog2(RAS_DEPTH + 1);
    localparam int            IW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [D-1:0]  PC_ONE  = {{(D-1){1'b0}}, 1'b1};

    function automatic logic [D-1:0] sext_ofs(input logic [OFS_W-1:0] v);
        return D'($signed(v));
    endfunction

    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          red_q, red_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [D-1:0]  stack_q [RAS_DEPTH];
    logic          push_s;
    logic          empty_s, full_s;
    logic [D-1:0]  pc_inc_s, top_s;
    logic [IW-1:0] top_idx_s, wr_idx_s;

    assign empty_s   = (cnt_q == CNT_ZERO);
    assign full_s    = (cnt_q == CNT_MAX);
    assign pc_inc_s  = pc_q + PC_ONE;
    // wr_idx_s only matters when not full, so truncation at count == depth is harmless
    assign top_idx_s = IW'(cnt_q - CNT_ONE);
    assign wr_idx_s  = IW'(cnt_q);
    assign top_s     = stack_q[top_idx_s];

    // Next-state selection with fixed priority stall > ret > call > branch > rel_branch
    always_comb begin
        pc_d   = pc_inc_s;
        cnt_d  = cnt_q;
        red_d  = 1'b0;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push_s = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (!empty_s) begin
                pc_d  = top_s;
                cnt_d = cnt_q - CNT_ONE;
                red_d = 1'b1;
            end else begin
                unf_d = 1'b1;
            end
        end else if (call) begin
            pc_d  = target;
            red_d = 1'b1;
            if (!full_s) begin
                push_s = 1'b1;
                cnt_d  = cnt_q + CNT_ONE;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (branch) begin
            pc_d  = target;
            red_d = 1'b1;
        end else if (rel_branch) begin
            pc_d  = pc_q + sext_ofs(offset);
            red_d = 1'b1;
        end else begin
            pc_d = pc_inc_s;
        end
    end

    // State registers and stack storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VEC;
            cnt_q <= CNT_ZERO;
            red_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_q[i] <= {D{1'b0}};
            end
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            red_q <= red_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (push_s) begin
                stack_q[wr_idx_s] <= pc_inc_s;
            end
        end
    end

    assign prog_ctr  = pc_q;
    assign redirect  = red_q;
    assign ras_empty = empty_s;
    assign ras_full  = full_s;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Scoreboard bench for pc_ras (D=8, DEPTH=4): driver queues hand-computed
// expectations, a monitor pops and compares one per clock after each edge.
module tb_pc_ras;

    logic       clk;
    logic       reset;
    logic       stall, branch, rel_branch, call, ret;
    logic [7:0] target, offset;
    logic [7:0] prog_ctr;
    logic       redirect, ras_empty, ras_full, ras_ovf, ras_unf;

    typedef struct packed {
        logic [7:0] pc;
        logic       red;
        logic       emp;
        logic       full;
        logic       ovf;
        logic       unf;
    } obs_t;

    obs_t  exp_q [$];
    string name_q [$];
    int    n_checks = 0;
    int    n_fail   = 0;

    pc_ras #(.D(8), .OFS_W(8), .RAS_DEPTH(4), .RESET_VEC(8'h00)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .rel_branch(rel_branch), .call(call), .ret(ret), .target(target),
        .offset(offset), .prog_ctr(prog_ctr), .redirect(redirect),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
        .ras_unf(ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.pc = prog_ctr; o.red = redirect; o.emp = ras_empty;
        o.full = ras_full; o.ovf = ras_ovf; o.unf = ras_unf;
        return o;
    endfunction

    task automatic compare(input string nm, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pc=%h red=%b emp=%b full=%b ovf=%b unf=%b, expected pc=%h red=%b emp=%b full=%b ovf=%b unf=%b",
                     nm, act.pc, act.red, act.emp, act.full, act.ovf, act.unf,
                     exp.pc, exp.red, exp.emp, exp.full, exp.ovf, exp.unf);
        end
    endtask

    // Monitor: one registered observation per rising edge, sampled 1 time unit later
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            compare(name_q.pop_front(), observe(), exp_q.pop_front());
        end
    end

    // ctl = {stall, ret, call, branch, rel_branch}; exp = {pc, red, emp, full, ovf, unf}
    task automatic step(input string nm, input logic [4:0] ctl, input logic [7:0] tgt,
                        input logic [7:0] ofs, input logic [7:0] epc,
                        input logic [4:0] eflags);
        @(negedge clk);
        {stall, ret, call, branch, rel_branch} = ctl;
        target = tgt;
        offset = ofs;
        exp_q.push_back({epc, eflags});
        name_q.push_back(nm);
    endtask

    task automatic drain();
        int budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations still pending, required 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    localparam logic [4:0] IDLE = 5'b00000;
    localparam logic [4:0] STL  = 5'b10000;
    localparam logic [4:0] RET  = 5'b01000;
    localparam logic [4:0] CAL  = 5'b00100;
    localparam logic [4:0] BR   = 5'b00010;
    localparam logic [4:0] REL  = 5'b00001;

    initial begin
        reset = 1'b0;
        {stall, ret, call, branch, rel_branch} = IDLE;
        target = 8'h00;
        offset = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        compare("reset_state", observe(), {8'h00, 5'b01000});
        reset = 1'b1;

        // Sequential run after reset release
        step("seq1", IDLE, 8'h00, 8'h00, 8'h01, 5'b01000);
        step("seq2", IDLE, 8'h00, 8'h00, 8'h02, 5'b01000);
        step("seq3", IDLE, 8'h00, 8'h00, 8'h03, 5'b01000);
        drain();

        // Asynchronous reset between edges
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        compare("async_reset", observe(), {8'h00, 5'b01000});
        reset = 1'b1;

        // Wrap and relative branching
        step("br_fe",    BR,   8'hFE, 8'h00, 8'hFE, 5'b11000);
        step("seq_ff",   IDLE, 8'h00, 8'h00, 8'hFF, 5'b01000);
        step("wrap_00",  IDLE, 8'h00, 8'h00, 8'h00, 5'b01000);
        step("br_05",    BR,   8'h05, 8'h00, 8'h05, 5'b11000);
        step("rel_m5",   REL,  8'h00, 8'hFB, 8'h00, 5'b11000);
        step("br_fe2",   BR,   8'hFE, 8'h00, 8'hFE, 5'b11000);
        step("rel_p4",   REL,  8'h00, 8'h04, 8'h02, 5'b11000);
        step("rel_zero", REL,  8'h00, 8'h00, 8'h02, 5'b11000);
        step("rel_m3w",  REL,  8'h00, 8'hFD, 8'hFF, 5'b11000);

        // Call/return nesting
        step("br_10",    BR,   8'h10, 8'h00, 8'h10, 5'b11000);
        step("call_40",  CAL,  8'h40, 8'h00, 8'h40, 5'b10000);
        step("seq_41",   IDLE, 8'h00, 8'h00, 8'h41, 5'b00000);
        step("call_80",  CAL,  8'h80, 8'h00, 8'h80, 5'b10000);
        step("ret_42",   RET,  8'h00, 8'h00, 8'h42, 5'b10000);
        step("ret_11",   RET,  8'h00, 8'h00, 8'h11, 5'b11000);

        // Overflow: four pushes fill the stack, fifth call jumps but sets ovf
        step("call_a",   CAL,  8'h20, 8'h00, 8'h20, 5'b10000);
        step("call_b",   CAL,  8'h30, 8'h00, 8'h30, 5'b10000);
        step("call_c",   CAL,  8'h50, 8'h00, 8'h50, 5'b10000);
        step("call_d",   CAL,  8'h60, 8'h00, 8'h60, 5'b10100);
        step("call_ovf", CAL,  8'h70, 8'h00, 8'h70, 5'b10110);

        // LIFO unwinding then underflow
        step("ret_51",   RET,  8'h00, 8'h00, 8'h51, 5'b10010);
        step("ret_31",   RET,  8'h00, 8'h00, 8'h31, 5'b10010);
        step("ret_21",   RET,  8'h00, 8'h00, 8'h21, 5'b10010);
        step("ret_12",   RET,  8'h00, 8'h00, 8'h12, 5'b11010);
        step("ret_unf",  RET,  8'h00, 8'h00, 8'h13, 5'b01011);
        step("sticky",   IDLE, 8'h00, 8'h00, 8'h14, 5'b01011);

        // Priority and stall
        step("call_90",  CAL,  8'h90, 8'h00, 8'h90, 5'b10011);
        step("stl_call", STL | CAL, 8'hA0, 8'h00, 8'h90, 5'b00011);
        step("stl_ret",  STL | RET, 8'h00, 8'h00, 8'h90, 5'b00011);
        step("ret_call", RET | CAL, 8'hB0, 8'h00, 8'h15, 5'b11011);
        step("br_rel",   BR | REL,  8'hC0, 8'h10, 8'hC0, 5'b11011);
        step("call_br",  CAL | BR,  8'hD0, 8'h00, 8'hD0, 5'b10011);
        step("ret_d1",   RET,  8'h00, 8'h00, 8'hC1, 5'b11011);
        step("idle_end", IDLE, 8'h00, 8'h00, 8'hC2, 5'b01011);
        drain();

        // Reset clears sticky flags and stack
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        compare("reset_clear", observe(), {8'h00, 5'b01000});
        reset = 1'b1;
        step("post_rst", IDLE, 8'h00, 8'h00, 8'h01, 5'b01000);
        step("post_ret", RET,  8'h00, 8'h00, 8'h02, 5'b01001);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
